// File: rtl/wb_stage_if.sv
// Valid/ready bus between the memory stage and the write-back register stage.
interface wb_stage_if #(
    parameter int LANES  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*ADDR_W-1:0]  in_wd;
    logic [LANES-1:0]         in_wreg;
    logic [LANES*DATA_W-1:0]  in_wdata;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*ADDR_W-1:0]  out_wd;
    logic [LANES-1:0]         out_wreg;
    logic [LANES*DATA_W-1:0]  out_wdata;

    modport slave (
        input  in_valid, in_wd, in_wreg, in_wdata, out_ready,
        output in_ready, out_valid, out_wd, out_wreg, out_wdata
    );

    modport master (
        output in_valid, in_wd, in_wreg, in_wdata, out_ready,
        input  in_ready, out_valid, out_wd, out_wreg, out_wdata
    );
endinterface

// File: rtl/wb_stage_reg.sv
// MEM->WB pipeline register: LANES write-back records per beat, optional 2-entry
// skid buffer, flush, write-enable sanitising and a saturating stall counter.
module wb_stage_reg #(
    parameter int LANES  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    wb_stage_if.slave         if_wb,
    output logic [CNT_W-1:0]  o_stall_cnt
);
    typedef struct packed {
        logic [LANES*ADDR_W-1:0] wd;
        logic [LANES-1:0]        wreg;
        logic [LANES*DATA_W-1:0] wdata;
    } beat_t;

    beat_t            r_main, r_skid;
    logic             r_main_vld, r_skid_vld;
    logic [CNT_W-1:0] r_cnt;
    beat_t            w_in;
    logic [LANES-1:0] w_wreg_san;
    logic             w_in_ready, w_acc, w_drain;

    // A lane loses its write if it targets $zero or a higher lane writes the same register.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_san
        logic [LANES-1:0] w_shadow;
        for (genvar gj = 0; gj < LANES; gj++) begin : g_cmp
            if (gj > gi) begin : g_hi
                assign w_shadow[gj] = if_wb.in_wreg[gj] &&
                    (if_wb.in_wd[gj*ADDR_W +: ADDR_W] == if_wb.in_wd[gi*ADDR_W +: ADDR_W]);
            end else begin : g_lo
                assign w_shadow[gj] = 1'b0;
            end
        end
        assign w_wreg_san[gi] = if_wb.in_wreg[gi] &&
                                (if_wb.in_wd[gi*ADDR_W +: ADDR_W] != '0) && !(|w_shadow);
    end

    assign w_in.wd    = if_wb.in_wd;
    assign w_in.wreg  = w_wreg_san;
    assign w_in.wdata = if_wb.in_wdata;

    assign w_in_ready = !i_rst && ((SKID != 0) ? !r_skid_vld
                                               : (!r_main_vld || if_wb.out_ready));
    assign w_acc      = if_wb.in_valid && w_in_ready;
    assign w_drain    = r_main_vld && if_wb.out_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_main     <= '0;
            r_skid     <= '0;
        end else if (SKID != 0) begin
            if (w_drain) begin
                if (r_skid_vld) begin
                    r_main     <= r_skid;
                    r_skid_vld <= 1'b0;
                    r_skid     <= '0;
                end else if (w_acc) begin
                    r_main <= w_in;
                end else begin
                    r_main_vld <= 1'b0;
                end
            end else if (w_acc) begin
                if (r_main_vld) begin
                    r_skid     <= w_in;
                    r_skid_vld <= 1'b1;
                end else begin
                    r_main     <= w_in;
                    r_main_vld <= 1'b1;
                end
            end
        end else begin
            if (w_acc) begin
                r_main     <= w_in;
                r_main_vld <= 1'b1;
            end else if (w_drain) begin
                r_main_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= '0;
        else if (r_main_vld && !if_wb.out_ready && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    // Drained entries keep stale fields, so the outputs are gated to a NOP record.
    assign if_wb.in_ready  = w_in_ready;
    assign if_wb.out_valid = r_main_vld;
    assign if_wb.out_wd    = r_main_vld ? r_main.wd    : '0;
    assign if_wb.out_wreg  = r_main_vld ? r_main.wreg  : '0;
    assign if_wb.out_wdata = r_main_vld ? r_main.wdata : '0;
    assign o_stall_cnt     = r_cnt;
endmodule

// File: doc/wb_stage_reg.md
Name: wb_stage_reg

Overview:
- Parametrised MEM->WB pipeline register for the multi-issue core; generalises the single-lane write-back latch.
- Carries LANES write-back records {wd, wreg, wdata} per beat under a valid/ready handshake, with an optional 2-entry skid buffer, flush, and write-enable sanitising.
- Also counts back-pressure cycles.
- Sits between the memory stage and the register-file write ports.

Parameters:
LANES, 2, number of write-back lanes per beat (>=1)
ADDR_W, 5, register address width
DATA_W, 32, write data width
SKID, 1, 1 = 2-entry skid buffer (in_ready registered-state only); 0 = single register, in_ready depends on out_ready
CNT_W, 16, width of stall counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  discard all buffered beats
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat
in_wd  input  LANES*ADDR_W  per-lane destination address, lane i at [i*ADDR_W +: ADDR_W]
in_wreg  input  LANES  per-lane write enable
in_wdata  input  LANES*DATA_W  per-lane write data
out_valid  output  1  beat presented to write-back
out_ready  input  1  write-back accepts beat
out_wd  output  LANES*ADDR_W  per-lane address
out_wreg  output  LANES  per-lane sanitised write enable
out_wdata  output  LANES*DATA_W  per-lane data
stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Accept = in_valid & in_ready.
- Drain = out_valid & out_ready.
- Latency: accepted beat appears on out_* the next cycle at the earliest.
- Reset (rst=1 at edge):
  - main and skid entries invalid, their fields zero.
  - stall_cnt=0.
  - in_ready forced 0 combinationally while rst=1.
  - out_valid=0, out_wd=0, out_wreg=0, out_wdata=0.
  - Reset mid-transfer drops all beats.
- Output gating: when out_valid=0, out_wd, out_wreg and out_wdata are all zero (NOP record).
- SKID=1 states:
  - EMPTY (main invalid):
    - in_ready=1.
    - Accept -> ONE, main<=in.
  - ONE (main valid, skid invalid):
    - in_ready=1.
    - Drain & accept -> ONE, main<=in.
    - Drain & no accept -> EMPTY.
    - No drain & accept -> TWO, skid<=in.
    - Else hold.
  - TWO (both valid):
    - in_ready=0.
    - Drain -> ONE, main<=skid, skid cleared.
    - Else hold.
- SKID=0:
  - in_ready = !main_valid | out_ready.
  - Accept loads main.
  - Drain without accept -> main invalid.
  - State TWO is unreachable.
- Beat order is strictly FIFO; no beat is ever duplicated or reordered.
- flush=1 at edge: main and skid invalidated and zeroed. Any accept in the same cycle is dropped; flush has priority over accept and drain.
  - in_ready is unaffected combinationally.
  - stall_cnt is not cleared.
- Sanitising, applied at capture into main/skid:
  - Lane with wd==0 has wreg forced 0 (register $zero never written).
  - If lanes i<j both have wreg=1 with equal wd, lane i's wreg is forced 0. The highest lane wins (program order).
  - wd and wdata are stored unchanged even when wreg is forced 0.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & !out_ready.
  - Saturates at all-ones; no wrap.
  - Cleared only by rst.
- rst has priority over flush; flush has priority over handshake.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, all out_* 0, stall_cnt=0.
- Streaming (SKID=1, out_ready=1): beats A,B,C on consecutive cycles -> out_valid from the cycle after A, outputs A,B,C on consecutive cycles, in_ready constant 1.
- Back-pressure (SKID=1):
  - Stimulus: send A,B,C, with out_ready=0 for 3 cycles after A appears.
  - B is held in skid; in_ready drops to 0 after B; C is held upstream.
  - stall_cnt=3.
  - On release, out = A,B,C in order with no loss.
- Flush: in state TWO assert flush together with in_valid=1 beat D -> next cycle out_valid=0, outputs zero, D not delivered; next accepted beat E delivered normally.
- Sanitise (LANES=2):
  - lane0 {wd=5, wreg=1}, lane1 {wd=5, wreg=1} -> out_wreg=2'b10.
  - lane0 {wd=0, wreg=1} -> out_wreg[0]=0, out_wd[0]=0.
- Saturation (CNT_W=4): out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
